// File: rtl/debounce_pkg.sv
// Shared state encodings and counter sizing for the switch debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LO  = 2'b00,
    CHK_HI = 2'b01,
    ST_HI  = 2'b11,
    CHK_LO = 2'b10
  } state_t;

  // Counter must hold values 0..DEBOUNCE_CYCLES.
  function automatic int cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: 2-FF synchronizer, qualification FSM/counter, and
// registered level plus rise/fall pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic s1;
  logic s;
  state_t state;
  state_t state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic q_n;
  logic rise_n;
  logic fall_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= raw;
      s  <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LO;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      q     <= q_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  // A pending check restarts from a count of 1: the sample that leaves the
  // stable state is already the first qualifying one.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    q_n     = q;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      ST_LO: begin
        if (s) begin
          state_n = CHK_HI;
          cnt_n   = CW'(1);
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_n = ST_LO;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_HI;
          cnt_n   = '0;
          q_n     = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_HI: begin
        if (!s) begin
          state_n = CHK_LO;
          cnt_n   = CW'(1);
        end
      end
      CHK_LO: begin
        if (s) begin
          state_n = ST_HI;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_LO;
          cnt_n   = '0;
          q_n     = 1'b0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = ST_LO;
        cnt_n   = '0;
        q_n     = 1'b0;
      end
    endcase
  end

  a_cnt_max: assert property (@(posedge clk) disable iff (rst) cnt <= CNT_LAST);

endmodule

// File: rtl/switch_debouncer.sv
// WIDTH independent debounced switch channels with level and edge outputs.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .raw (raw[i]),
      .q   (q[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: stimulus queues expected pulse events,
// a monitor matches every rise/fall the DUT presents against that queue.
module tb_switch_debouncer;
  import debounce_pkg::*;

  localparam int WIDTH = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  // Raw driven at the negedge while cyc==n is sampled at edge n+1; q and
  // pulses update DEBOUNCE_CYCLES edges after the synchronizer output moves.
  localparam int LAT = DEBOUNCE_CYCLES + 2;
  localparam int W = 20;

  logic clk;
  logic rst;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  int cyc;
  int vectors;
  int miscompares;
  logic [W-1:0] exp_q[$];

  switch_debouncer #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .raw (raw),
    .q   (q),
    .rise(rise),
    .fall(fall)
  );

  // clock / reset-relative cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int at, input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] f);
    exp_q.push_back({at[15:0], r, f});
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && int'(exp_q[0][19:4]) < cyc) begin
        logic [W-1:0] m;
        m = exp_q.pop_front();
        chk("missed_pulse_cycle", 32'(cyc), 32'(m[19:4]));
      end
      if ((rise | fall) != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {28'd0, rise, fall}, 32'd0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          chk("pulse_event", {cyc[15:0], 12'd0, rise, fall}, {e[19:4], 12'd0, e[3:0]});
        end
      end
    end
  end

  // driver
  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    raw = '0;
    repeat (3) @(negedge clk);
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_rise", 32'(rise), 32'd0);
    chk("reset_fall", 32'(fall), 32'd0);
    rst = 1'b0;

    // bounce on ch0: three raw-high samples, never qualifies
    goto(3);  raw[0] = 1'b1;
    goto(6);  raw[0] = 1'b0;
    goto(9);  chk("bounce_q", 32'(q), 32'd0);

    // ch0 rises: raw set before edge 10, q from edge 15
    raw[0] = 1'b1;
    push_exp(9 + LAT, 2'b01, 2'b00);
    goto(14); chk("rise_q_before", 32'(q), 32'd0);
    goto(15); chk("rise_q_at", 32'(q), 32'b01);

    // ch0 falls: raw cleared before edge 30, q low from edge 35
    goto(29); raw[0] = 1'b0;
    push_exp(29 + LAT, 2'b00, 2'b01);
    goto(34); chk("fall_q_before", 32'(q), 32'b01);
    goto(35); chk("fall_q_at", 32'(q), 32'b00);

    // both channels together, up then down
    goto(40); raw = 2'b11;
    push_exp(40 + LAT, 2'b11, 2'b00);
    goto(46); chk("both_rise_q", 32'(q), 32'b11);
    goto(50); raw = 2'b00;
    push_exp(50 + LAT, 2'b00, 2'b11);
    goto(56); chk("both_fall_q", 32'(q), 32'b00);

    // ch0 high, then ch1 mid-check when async reset hits
    goto(60); raw = 2'b01;
    push_exp(60 + LAT, 2'b01, 2'b00);
    goto(66); chk("pre_reset_q", 32'(q), 32'b01);
    goto(70); raw = 2'b11;
    goto(74); chk("chk_hi_q", 32'(q), 32'b01);
    chk("queue_empty_pre_reset", 32'(exp_q.size()), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("async_q", 32'(q), 32'd0);
    chk("async_rise", 32'(rise), 32'd0);
    chk("async_fall", 32'(fall), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_exp(0 + LAT, 2'b11, 2'b00);
    goto(5);  chk("post_reset_q_before", 32'(q), 32'd0);
    goto(6);  chk("post_reset_q", 32'(q), 32'b11);

    // ch1 chatter every cycle: no level change, no pulses
    goto(10);
    for (int i = 0; i < 50; i++) begin
      raw[1] = ~raw[1];
      @(negedge clk);
    end
    goto(cyc + 10);
    chk("chatter_q", 32'(q), 32'b11);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // hard time bound
  initial begin
    #100000;
    $display("FAIL timeout at cyc %0d", cyc);
    $fatal(1);
  end

endmodule
